// File: rtl/reg_file_cfg.sv
// ============================================================================
// Module      : reg_file_cfg
// Description : Parametrised configuration register file. Per-entry reset
//               image, byte-strobed writes, 1- or 2-cycle read pipeline,
//               out-of-range address flagging and a write-lock entry that
//               protects the exported entries. The first NUM_EXPORT entries
//               are exported flat on REG_EXPORT (entry 0 in the LSBs).
//               Optional feature macro: REG_FILE_PARITY_EN (adds a stored
//               even-parity bit per entry and the Par_Err output).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_cfg #(
    parameter int                      DATA_W     = 8,
    parameter int                      DEPTH      = 16,
    parameter int                      ADDR_W     = 4,
    parameter int                      RD_LAT     = 1,
    parameter int                      NUM_EXPORT = 4,
    parameter int                      LOCK_IDX   = 15,
    parameter logic [DEPTH*DATA_W-1:0] RST_VALS   = 128'h0000_0000_0000_0000_0000_0000_0823_0000
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         WrEN,
    input  logic                         RdEN,
    input  logic [DATA_W-1:0]            WrData,
    input  logic [DATA_W/8-1:0]          WrStrb,
    input  logic [ADDR_W-1:0]            Address,
    output logic [DATA_W-1:0]            Rd_Data,
    output logic                         Rd_Data_VLD,
    output logic                         Addr_Err,
`ifdef REG_FILE_PARITY_EN
    output logic                         Par_Err,
`endif
    output logic [NUM_EXPORT*DATA_W-1:0] REG_EXPORT
);

    localparam int                c_NB    = DATA_W / 8;
    // Comparisons are done one bit wider so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_NEXP  = (ADDR_W+1)'(NUM_EXPORT);
    localparam logic [ADDR_W-1:0] c_LOCK  = ADDR_W'(LOCK_IDX);

    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [DATA_W-1:0] w_mem_d [DEPTH];

    logic              w_in_range;
    logic              w_lock_tgt;
    logic              w_wr_ok;
    logic              w_rd_req;
    logic [DATA_W-1:0] w_rd_word;

    logic              r_s1_vld_q,  w_s1_vld_d;
    logic [DATA_W-1:0] r_s1_data_q, w_s1_data_d;
    logic              r_s1_err_q,  w_s1_err_d;
    logic              r_wr_err_q,  w_wr_err_d;
    logic              w_rd_err_out;

    assign w_in_range = ({1'b0, Address} < c_DEPTH);
    // The lock entry stays writable even if it were placed inside the export range
    assign w_lock_tgt = ({1'b0, Address} < c_NEXP) && (Address != c_LOCK);
    assign w_wr_ok    = WrEN && w_in_range && !(r_mem_q[LOCK_IDX][0] && w_lock_tgt);
    assign w_rd_req   = RdEN && !WrEN;

    // Next array contents: merge strobed bytes into the addressed entry
    always_comb begin
        w_mem_d = r_mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_ok && (Address == ADDR_W'(i))) begin
                for (int k = 0; k < c_NB; k++) begin
                    if (WrStrb[k]) begin
                        w_mem_d[i][8*k +: 8] = WrData[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read mux of the current array contents (zero when out of range)
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_W'(i)) begin
                w_rd_word = r_mem_q[i];
            end
        end
    end

    // First read stage next-state; data holds between reads
    always_comb begin
        w_s1_vld_d  = w_rd_req;
        w_s1_data_d = r_s1_data_q;
        if (w_rd_req) begin
            w_s1_data_d = w_in_range ? w_rd_word : '0;
        end
        w_s1_err_d  = w_rd_req && !w_in_range;
        w_wr_err_d  = WrEN && !w_in_range;
    end

    // Array and first read stage registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
            end
            r_s1_vld_q  <= 1'b0;
            r_s1_data_q <= '0;
            r_s1_err_q  <= 1'b0;
            r_wr_err_q  <= 1'b0;
        end else begin
            r_mem_q     <= w_mem_d;
            r_s1_vld_q  <= w_s1_vld_d;
            r_s1_data_q <= w_s1_data_d;
            r_s1_err_q  <= w_s1_err_d;
            r_wr_err_q  <= w_wr_err_d;
        end
    end

`ifdef REG_FILE_PARITY_EN
    logic [DEPTH-1:0] r_par_q, w_par_d;
    logic             w_rd_par_err;
    logic             r_s1_perr_q, w_s1_perr_d;
    logic             w_perr_out;

    // Parity is only recomputed for the entry actually written, so a stored
    // mismatch survives until that entry is rewritten
    always_comb begin
        w_par_d = r_par_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_ok && (Address == ADDR_W'(i))) begin
                w_par_d[i] = ^w_mem_d[i];
            end
        end
    end

    // Compare stored parity of the addressed entry against its data
    always_comb begin
        w_rd_par_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_W'(i)) begin
                w_rd_par_err = (^r_mem_q[i]) != r_par_q[i];
            end
        end
        w_s1_perr_d = w_rd_req && w_in_range && w_rd_par_err;
    end

    // Parity storage and first-stage parity flag
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par_q[i] <= ^RST_VALS[i*DATA_W +: DATA_W];
            end
            r_s1_perr_q <= 1'b0;
        end else begin
            r_par_q     <= w_par_d;
            r_s1_perr_q <= w_s1_perr_d;
        end
    end

    assign Par_Err = w_perr_out;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_vld_q;
            logic [DATA_W-1:0] r_s2_data_q, w_s2_data_d;
            logic              r_s2_err_q;

            // Second stage only reloads data when a read leaves stage one
            always_comb begin
                w_s2_data_d = r_s1_vld_q ? r_s1_data_q : r_s2_data_q;
            end

            // Second read stage registers
            always_ff @(posedge CLK) begin
                if (rst) begin
                    r_s2_vld_q  <= 1'b0;
                    r_s2_data_q <= '0;
                    r_s2_err_q  <= 1'b0;
                end else begin
                    r_s2_vld_q  <= r_s1_vld_q;
                    r_s2_data_q <= w_s2_data_d;
                    r_s2_err_q  <= r_s1_err_q;
                end
            end

`ifdef REG_FILE_PARITY_EN
            logic r_s2_perr_q;
            // Parity flag follows the read through the second stage
            always_ff @(posedge CLK) begin
                if (rst) begin
                    r_s2_perr_q <= 1'b0;
                end else begin
                    r_s2_perr_q <= r_s1_perr_q;
                end
            end
            assign w_perr_out = r_s2_perr_q;
`endif
            assign Rd_Data      = r_s2_data_q;
            assign Rd_Data_VLD  = r_s2_vld_q;
            assign w_rd_err_out = r_s2_err_q;
        end else begin : g_lat1
`ifdef REG_FILE_PARITY_EN
            assign w_perr_out = r_s1_perr_q;
`endif
            assign Rd_Data      = r_s1_data_q;
            assign Rd_Data_VLD  = r_s1_vld_q;
            assign w_rd_err_out = r_s1_err_q;
        end
    endgenerate

    // Read errors are aligned with their VLD; write errors appear the cycle after
    assign Addr_Err = w_rd_err_out | r_wr_err_q;

    generate
        for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
            assign REG_EXPORT[g*DATA_W +: DATA_W] = r_mem_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_cfg.sv
// ============================================================================
// Module      : tb_reg_file_cfg
// Description : Scoreboard bench for reg_file_cfg. Three instances:
//               u0 default (RD_LAT=1), u1 RD_LAT=2, u2 DEPTH=12 / LOCK_IDX=11.
//               Stimulus pushes expected read/error events; a negedge monitor
//               pops and compares data, error flag and arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_cfg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst     [3];
    logic       wr_en   [3];
    logic       rd_en   [3];
    logic [7:0] wr_data [3];
    logic [0:0] wr_strb [3];
    logic [3:0] addr    [3];
    logic [7:0] rd_data [3];
    logic       rd_vld  [3];
    logic       a_err   [3];
    logic [31:0] reg_exp [3];
`ifdef REG_FILE_PARITY_EN
    logic       par_err [3];
`endif

    reg_file_cfg u0 (
        .CLK(CLK), .rst(rst[0]), .WrEN(wr_en[0]), .RdEN(rd_en[0]),
        .WrData(wr_data[0]), .WrStrb(wr_strb[0]), .Address(addr[0]),
        .Rd_Data(rd_data[0]), .Rd_Data_VLD(rd_vld[0]), .Addr_Err(a_err[0]),
`ifdef REG_FILE_PARITY_EN
        .Par_Err(par_err[0]),
`endif
        .REG_EXPORT(reg_exp[0])
    );

    reg_file_cfg #(.RD_LAT(2)) u1 (
        .CLK(CLK), .rst(rst[1]), .WrEN(wr_en[1]), .RdEN(rd_en[1]),
        .WrData(wr_data[1]), .WrStrb(wr_strb[1]), .Address(addr[1]),
        .Rd_Data(rd_data[1]), .Rd_Data_VLD(rd_vld[1]), .Addr_Err(a_err[1]),
`ifdef REG_FILE_PARITY_EN
        .Par_Err(par_err[1]),
`endif
        .REG_EXPORT(reg_exp[1])
    );

    reg_file_cfg #(.DEPTH(12), .LOCK_IDX(11),
                   .RST_VALS(96'h0000_0000_0000_0000_0823_0000)) u2 (
        .CLK(CLK), .rst(rst[2]), .WrEN(wr_en[2]), .RdEN(rd_en[2]),
        .WrData(wr_data[2]), .WrStrb(wr_strb[2]), .Address(addr[2]),
        .Rd_Data(rd_data[2]), .Rd_Data_VLD(rd_vld[2]), .Addr_Err(a_err[2]),
`ifdef REG_FILE_PARITY_EN
        .Par_Err(par_err[2]),
`endif
        .REG_EXPORT(reg_exp[2])
    );

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;
    int lat [3] = '{1, 2, 1};

    // Event entry: [41:10] expected cycle, [9] read VLD, [8] Addr_Err, [7:0] data
    logic [41:0] q0[$];
    logic [41:0] q1[$];
    logic [41:0] q2[$];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] rv(input int a);
        if (a == 2) return 8'h23;
        if (a == 3) return 8'h08;
        return 8'h00;
    endfunction

    task automatic push(input int s, input logic [41:0] e);
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic drive(input int s, input logic we, input logic re,
                         input logic [3:0] a, input logic [7:0] d, input logic st);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0;
            rd_en[i] = 1'b0;
        end
        wr_en[s]   = we;
        rd_en[s]   = re;
        addr[s]    = a;
        wr_data[s] = d;
        wr_strb[s] = st;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic rd(input int s, input logic [3:0] a, input logic [7:0] d, input logic e);
        drive(s, 1'b0, 1'b1, a, 8'h00, 1'b0);
        push(s, {32'(cyc + lat[s]), 1'b1, e, d});
    endtask

    task automatic wr(input int s, input logic [3:0] a, input logic [7:0] d,
                      input logic st, input logic werr);
        drive(s, 1'b1, 1'b0, a, d, st);
        if (werr) push(s, {32'(cyc + 1), 1'b0, 1'b1, 8'h00});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic mon(input int s, input logic v, input logic e, input logic [7:0] d);
        logic [41:0] x;
        bit have;
        if (!(v || e)) return;
        have = 0;
        x    = '0;
        case (s)
            0:       if (q0.size() > 0) begin x = q0.pop_front(); have = 1; end
            1:       if (q1.size() > 0) begin x = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1; end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL dut%0d unexpected event: vld=%b err=%b data=%h cyc=%0d, required none",
                     s, v, e, d, cyc);
        end else if (x[41:10] != 32'(cyc) || x[9] != v || x[8] != e || (v && d !== x[7:0])) begin
            n_err++;
            $display("FAIL dut%0d event: got cyc=%0d vld=%b err=%b data=%h, required cyc=%0d vld=%b err=%b data=%h",
                     s, cyc, v, e, d, x[41:10], x[9], x[8], x[7:0]);
        end
    endtask

    always @(negedge CLK) begin
        for (int s = 0; s < 3; s++) mon(s, rd_vld[s], a_err[s], rd_data[s]);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; wr_en[i] = 1'b0; rd_en[i] = 1'b0;
            addr[i] = 4'd0; wr_data[i] = 8'h00; wr_strb[i] = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Reset image and read output state
        check("rst_export0", reg_exp[0], 32'h0823_0000);
        check("rst_export1", reg_exp[1], 32'h0823_0000);
        check("rst_export2", reg_exp[2], 32'h0823_0000);
        check("rst_rddata0", {24'h0, rd_data[0]}, 32'h0);

        // Back-to-back reads of every entry
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) rd(s, 4'(a), rv(a), 1'b0);
        end
        for (int a = 0; a < 12; a++) rd(2, 4'(a), rv(a), 1'b0);
        idle();

        // Write then read next cycle, both latencies
        wr(0, 4'd1, 8'hA5, 1'b1, 1'b0);
        rd(0, 4'd1, 8'hA5, 1'b0);
        wr(1, 4'd1, 8'hA5, 1'b1, 1'b0);
        rd(1, 4'd1, 8'hA5, 1'b0);
        idle();
        idle();
        check("wr_export0", reg_exp[0], 32'h0823_A500);
        check("wr_export1", reg_exp[1], 32'h0823_A500);
        check("hold_rddata0", {24'h0, rd_data[0]}, 32'h0000_00A5);

        // Strobe cleared: entry unchanged
        wr(0, 4'd5, 8'h33, 1'b0, 1'b0);
        rd(0, 4'd5, 8'h00, 1'b0);

        // Lock blocks exported entries silently, unlock restores writes
        wr(0, 4'd15, 8'h01, 1'b1, 1'b0);
        wr(0, 4'd0, 8'hFF, 1'b1, 1'b0);
        rd(0, 4'd0, 8'h00, 1'b0);
        idle();
        check("locked_export0", reg_exp[0], 32'h0823_A500);
        wr(0, 4'd15, 8'h00, 1'b1, 1'b0);
        wr(0, 4'd0, 8'hFF, 1'b1, 1'b0);
        rd(0, 4'd0, 8'hFF, 1'b0);
        rd(0, 4'd15, 8'h00, 1'b0);

        // Simultaneous write and read: write wins, no VLD
        drive(0, 1'b1, 1'b1, 4'd2, 8'h7E, 1'b1);
        rd(0, 4'd2, 8'h7E, 1'b0);
        idle();
        check("wrrd_export0", reg_exp[0], 32'h087E_A5FF);

        // Out-of-range accesses on the 12-entry instance
        rd(2, 4'd13, 8'h00, 1'b1);
        wr(2, 4'd13, 8'h55, 1'b1, 1'b1);
        idle();
        rd(2, 4'd12, 8'h00, 1'b1);
        rd(2, 4'd15, 8'h00, 1'b1);
        idle();
        wr(2, 4'd12, 8'h66, 1'b1, 1'b1);
        idle();
        check("oor_export2", reg_exp[2], 32'h0823_0000);
        wr(2, 4'd11, 8'h01, 1'b1, 1'b0);
        wr(2, 4'd0, 8'hFF, 1'b1, 1'b0);
        rd(2, 4'd0, 8'h00, 1'b0);
        rd(2, 4'd11, 8'h01, 1'b0);
        idle();

        // Reset during an in-flight 2-cycle read discards it
        wr(1, 4'd2, 8'h7E, 1'b1, 1'b0);
        idle();
        check("pre_rst_export1", reg_exp[1], 32'h087E_A500);
        drive(1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        rd_en[1] = 1'b0;
        rst[1]   = 1'b1;
        @(posedge CLK);
        #1;
        rst[1]   = 1'b0;
        check("post_rst_export1", reg_exp[1], 32'h0823_0000);
        check("post_rst_rddata1", {24'h0, rd_data[1]}, 32'h0);
        for (int a = 0; a < 16; a++) rd(1, 4'(a), rv(a), 1'b0);
        repeat (4) idle();

        check("pending0", 32'(q0.size()), 32'd0);
        check("pending1", 32'(q1.size()), 32'd0);
        check("pending2", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
